// File: rtl/fetch_stream_writer_pkg.sv
// Shared fetch-path definitions: instruction width, PC step and PC type.
package fetch_stream_writer_pkg;

  localparam int unsigned InstWidth = 32;
  localparam int unsigned PcIncr    = 4;

  typedef logic [31:0] pc_t;

  // Force a PC onto a word boundary (low bits of a redirect target are ignored).
  function automatic pc_t align_pc(input pc_t pc);
    return pc & ~pc_t'(PcIncr - 1);
  endfunction

endpackage

// File: rtl/fetch_stream_writer_fifo.sv
// Single-read single-write FIFO used as the fetch response buffer.
// Data written in a cycle becomes readable the following cycle.
// Overflow is not guarded here; the writer's credit counter prevents it.
module fetch_stream_writer_fifo #(
  parameter int unsigned Width     = 32,
  parameter int unsigned DepthLog2 = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_valid_i,
  input  logic [Width-1:0] wr_data_i,
  output logic             rd_valid_o,
  output logic [Width-1:0] rd_data_o,
  input  logic             rd_ready_i
);

  localparam int unsigned Depth = 2 ** DepthLog2;
  localparam int unsigned PtrW  = DepthLog2 + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic             do_rd;

  assign rd_valid_o = (wr_ptr_q != rd_ptr_q);
  assign rd_data_o  = mem_q[rd_ptr_q[DepthLog2-1:0]];
  assign do_rd      = rd_valid_o && rd_ready_i;
  assign wr_ptr_d   = wr_ptr_q + PtrW'(wr_valid_i);
  assign rd_ptr_d   = rd_ptr_q + PtrW'(do_rd);

  // Pointer state; clearing both pointers empties the buffer.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (wr_valid_i) begin
      mem_q[wr_ptr_q[DepthLog2-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/fetch_stream_writer.sv
// Fetch producer: issues sequential word reads, buffers in-order responses
// and streams them to decode tagged with their PC. A redirect restarts
// fetch and discards responses to requests issued before it.
module fetch_stream_writer
  import fetch_stream_writer_pkg::*;
#(
  parameter int unsigned DepthLog2 = 2,
  parameter logic [31:0] ResetAddr = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        req_valid_o,
  output logic [31:0] req_addr_o,
  input  logic        req_ready_i,
  input  logic        rsp_valid_i,
  input  logic [31:0] rsp_data_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_data_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i
);

  localparam int unsigned     Depth    = 2 ** DepthLog2;
  localparam int unsigned     CntW     = DepthLog2 + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  pc_t             pc_q, pc_d;
  pc_t             out_pc_q, out_pc_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] inflight_q, inflight_d;
  logic [CntW-1:0] drop_q, drop_d;

  logic issue, pop, push, drop_rsp;
  logic buf_valid, buf_rst_n, buf_rd_ready;

  // Issue is blocked while stale responses are pending so that every response
  // after the drop window belongs to the current fetch stream.
  assign req_valid_o  = !rst_i && !redirect_valid_i && (drop_q == '0) && (count_q < DepthCnt);
  assign req_addr_o   = pc_q;
  assign inst_valid_o = buf_valid && !redirect_valid_i && !rst_i;
  assign inst_pc_o    = out_pc_q;

  assign issue    = req_valid_o && req_ready_i;
  assign pop      = inst_valid_o && inst_ready_i;
  assign drop_rsp = rsp_valid_i && (drop_q != '0);
  assign push     = rsp_valid_i && (drop_q == '0);

  assign buf_rst_n    = !(rst_i || redirect_valid_i);
  assign buf_rd_ready = inst_ready_i && !redirect_valid_i;

  fetch_stream_writer_fifo #(
    .Width     (InstWidth),
    .DepthLog2 (DepthLog2)
  ) u_rsp_buf (
    .clk_i      (clk_i),
    .rst_ni     (buf_rst_n),
    .wr_valid_i (push),
    .wr_data_i  (rsp_data_i),
    .rd_valid_o (buf_valid),
    .rd_data_o  (inst_data_o),
    .rd_ready_i (buf_rd_ready)
  );

  // Next-state for PCs and credit counters; a redirect overrides everything
  // and converts all outstanding requests into responses to be discarded.
  always_comb begin
    pc_d       = pc_q;
    out_pc_d   = out_pc_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    if (redirect_valid_i) begin
      pc_d       = align_pc(redirect_pc_i);
      out_pc_d   = align_pc(redirect_pc_i);
      count_d    = '0;
      inflight_d = '0;
      drop_d     = drop_q + inflight_q - CntW'(rsp_valid_i);
    end else begin
      if (issue) pc_d = pc_q + pc_t'(PcIncr);
      if (pop) out_pc_d = out_pc_q + pc_t'(PcIncr);
      count_d    = count_q + CntW'(issue) - CntW'(pop);
      inflight_d = inflight_q + CntW'(issue) - CntW'(push);
      drop_d     = drop_q - CntW'(drop_rsp);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= ResetAddr;
      out_pc_q   <= ResetAddr;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      out_pc_q   <= out_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  // A response with nothing outstanding means the memory broke protocol.
  assert property (@(posedge clk_i) disable iff (rst_i)
    !(rsp_valid_i && (inflight_q == '0) && (drop_q == '0)));

endmodule
